// File: rtl/seq_det_pkg.sv
// ---------------------------------------------------------------------------
// seq_det_pkg
// Shared types and helpers for the parameterised serial sequence detector.
//   state_t   : detector state (S_FILL while history holds fewer than len
//               valid bits, S_DETECT once enough bits are present to match)
//   clamp_len : folds a requested pattern length into the legal range
//               [2, max_len]
// ---------------------------------------------------------------------------
package seq_det_pkg;

    typedef enum logic {
        S_FILL   = 1'b0,
        S_DETECT = 1'b1
    } state_t;

    localparam int MIN_LEN = 2;

    // Lengths of 0/1 make no sense for a sequence match and lengths beyond
    // the history width cannot be compared, so both ends are clamped.
    function automatic int clamp_len(input int raw_len, input int max_len);
        int result;
        result = raw_len;
        if (raw_len < MIN_LEN) begin
            result = MIN_LEN;
        end else if (raw_len > max_len) begin
            result = max_len;
        end
        return result;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// ---------------------------------------------------------------------------
// sat_counter
// Saturating event counter with a sticky saturation flag.
//   clk : clock (rising edge)
//   rst : synchronous active-high reset, clears cnt and sat
//   inc : count one event
//   clr : synchronous clear of cnt and sat; wins over a coincident inc
//   cnt : current count, holds at all-ones
//   sat : sticky, set when an event arrives while cnt is already all-ones
// ---------------------------------------------------------------------------
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] cnt,
    output logic         sat
);

    logic [W-1:0] cnt_reg;
    logic         sat_reg;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt_reg <= '0;
            sat_reg <= 1'b0;
        end else if (inc) begin
            if (&cnt_reg) begin
                sat_reg <= 1'b1;
            end else begin
                cnt_reg <= cnt_reg + W'(1);
            end
        end
    end

    assign cnt = cnt_reg;
    assign sat = sat_reg;

endmodule

// File: rtl/seq_detect_param.sv
// ---------------------------------------------------------------------------
// seq_detect_param
// Runtime-configurable serial pattern detector.
// Accepted bits shift into a MAX_LEN-bit history; a match is flagged when the
// newest len bits equal the configured pattern (pattern bit [len-1] is the
// oldest of those bits) and at least len bits have been accepted since the
// last configuration load / reset / non-overlapping match.
//   clk         : clock, rising edge
//   rst         : synchronous active-high reset
//   x, x_valid  : serial data bit and its qualifier
//   cfg_load    : capture cfg_pattern / cfg_len / cfg_overlap, restart search
//   cfg_pattern : pattern, bits at or above len are ignored
//   cfg_len     : pattern length, clamped to [2, MAX_LEN]
//   cfg_overlap : 1 = overlapping matches allowed
//   cnt_clr     : clear match_cnt and cnt_sat
//   y           : registered single-cycle match pulse
//   match_cnt   : saturating match count
//   cnt_sat     : sticky saturation flag
// ---------------------------------------------------------------------------
module seq_detect_param
    import seq_det_pkg::*;
#(
    parameter int          MAX_LEN     = 8,
    parameter int          CNT_W       = 8,
    parameter logic [31:0] RST_PATTERN = 32'h1,
    parameter int          RST_LEN     = 4,
    parameter bit          RST_OVERLAP = 1'b1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         x,
    input  logic                         x_valid,
    input  logic                         cfg_load,
    input  logic [MAX_LEN-1:0]           cfg_pattern,
    input  logic [$clog2(MAX_LEN+1)-1:0] cfg_len,
    input  logic                         cfg_overlap,
    input  logic                         cnt_clr,
    output logic                         y,
    output logic [CNT_W-1:0]             match_cnt,
    output logic                         cnt_sat
);

    localparam int LW = $clog2(MAX_LEN + 1);

    localparam logic [LW-1:0]      RST_LEN_CLAMPED = LW'(clamp_len(RST_LEN, MAX_LEN));
    localparam logic [MAX_LEN-1:0] RST_PAT         = RST_PATTERN[MAX_LEN-1:0];

    // configuration
    logic [MAX_LEN-1:0] pattern_reg;
    logic [LW-1:0]      len_reg;
    logic               overlap_reg;

    // detector state
    logic [MAX_LEN-1:0] hist_reg;
    logic [LW-1:0]      fill_reg;
    state_t             state_reg;
    logic               y_reg;

    logic [MAX_LEN-1:0] hist_next;
    logic [LW-1:0]      fill_next;
    logic [LW-1:0]      len_clamped;
    logic [MAX_LEN-1:0] len_mask;
    logic               accept;
    logic               enough_bits;
    logic               match;

    // A load edge ignores x so that the new configuration starts from a clean
    // history.
    assign accept      = x_valid & ~cfg_load;
    assign hist_next   = {hist_reg[MAX_LEN-2:0], x};
    assign fill_next   = (fill_reg == LW'(MAX_LEN)) ? fill_reg : fill_reg + LW'(1);
    assign len_clamped = LW'(clamp_len(int'(cfg_len), MAX_LEN));

    // Only the low len bits take part in the comparison.
    generate
        for (genvar gi = 0; gi < MAX_LEN; gi++) begin : g_mask
            assign len_mask[gi] = (gi < int'(len_reg));
        end
    endgenerate

    // In S_FILL fill < len, so the post-increment fill reaches len exactly on
    // the bit that completes the window; in S_DETECT the window is full.
    assign enough_bits = (state_reg == S_DETECT) || (fill_next == len_reg);

    assign match = accept && enough_bits &&
                   (((hist_next ^ pattern_reg) & len_mask) == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            pattern_reg <= RST_PAT;
            len_reg     <= RST_LEN_CLAMPED;
            overlap_reg <= RST_OVERLAP;
            hist_reg    <= '0;
            fill_reg    <= '0;
            state_reg   <= S_FILL;
            y_reg       <= 1'b0;
        end else if (cfg_load) begin
            pattern_reg <= cfg_pattern;
            len_reg     <= len_clamped;
            overlap_reg <= cfg_overlap;
            hist_reg    <= '0;
            fill_reg    <= '0;
            state_reg   <= S_FILL;
            y_reg       <= 1'b0;
        end else begin
            y_reg <= match;
            if (accept) begin
                hist_reg <= hist_next;
                if (match && !overlap_reg) begin
                    // Non-overlapping: the next match must be built from
                    // entirely new bits.
                    fill_reg  <= '0;
                    state_reg <= S_FILL;
                end else begin
                    fill_reg  <= fill_next;
                    state_reg <= (fill_next >= len_reg) ? S_DETECT : S_FILL;
                end
            end
        end
    end

    assign y = y_reg;

    sat_counter #(
        .W (CNT_W)
    ) u_cnt (
        .clk (clk),
        .rst (rst),
        .inc (match),
        .clr (cnt_clr),
        .cnt (match_cnt),
        .sat (cnt_sat)
    );

endmodule

// File: tb/tb_seq_detect_param.sv
// ---------------------------------------------------------------------------
// tb_seq_detect_param
// Two detector instances share all inputs: u_dut (CNT_W=8) and u_small
// (CNT_W=2) so counter saturation can be exercised quickly. Expected values
// come from a queue-based model of "bits accepted since the search restarted".
// ---------------------------------------------------------------------------
module tb_seq_detect_param;

    localparam int MAX_LEN = 8;
    localparam int LW      = 4;

    logic               clk = 1'b0;
    logic               rst = 1'b0;
    logic               x = 1'b0;
    logic               x_valid = 1'b0;
    logic               cfg_load = 1'b0;
    logic [MAX_LEN-1:0] cfg_pattern = '0;
    logic [LW-1:0]      cfg_len = '0;
    logic               cfg_overlap = 1'b0;
    logic               cnt_clr = 1'b0;

    logic               y;
    logic [7:0]         match_cnt;
    logic               cnt_sat;
    logic               y2;
    logic [1:0]         match_cnt2;
    logic               cnt_sat2;

    int tests = 0;
    int fails = 0;

    // model state
    bit          q[$];
    int          m_len;
    logic [31:0] m_pat;
    bit          m_ovl;
    bit          exp_y;
    int          exp_cnt;
    bit          exp_sat;
    int          exp_cnt2;
    bit          exp_sat2;
    int          dut_pulses;

    always #5 clk = ~clk;

    seq_detect_param #(.MAX_LEN(MAX_LEN), .CNT_W(8)) u_dut (
        .clk(clk), .rst(rst), .x(x), .x_valid(x_valid), .cfg_load(cfg_load),
        .cfg_pattern(cfg_pattern), .cfg_len(cfg_len), .cfg_overlap(cfg_overlap),
        .cnt_clr(cnt_clr), .y(y), .match_cnt(match_cnt), .cnt_sat(cnt_sat)
    );

    seq_detect_param #(.MAX_LEN(MAX_LEN), .CNT_W(2)) u_small (
        .clk(clk), .rst(rst), .x(x), .x_valid(x_valid), .cfg_load(cfg_load),
        .cfg_pattern(cfg_pattern), .cfg_len(cfg_len), .cfg_overlap(cfg_overlap),
        .cnt_clr(cnt_clr), .y(y2), .match_cnt(match_cnt2), .cnt_sat(cnt_sat2)
    );

    // One clock cycle: drive inputs, advance the model at the edge, then
    // leave the bench 1 time unit after the edge with controls idle.
    task automatic cyc(input bit xv, input bit vv, input bit ld, input bit clr, input bit rs);
        bit m;
        int req_len;
        x = xv; x_valid = vv; cfg_load = ld; cnt_clr = clr; rst = rs;
        @(posedge clk);
        m = 1'b0;
        if (rs) begin
            q.delete();
            m_pat = 32'h1; m_len = 4; m_ovl = 1'b1;
            exp_cnt = 0; exp_sat = 1'b0; exp_cnt2 = 0; exp_sat2 = 1'b0;
        end else begin
            if (ld) begin
                q.delete();
                req_len = int'(cfg_len);
                m_len = (req_len < 2) ? 2 : ((req_len > MAX_LEN) ? MAX_LEN : req_len);
                m_pat = 32'(cfg_pattern);
                m_ovl = cfg_overlap;
            end else if (vv) begin
                q.push_back(xv);
                if (q.size() >= m_len) begin
                    // newest bit pairs with pattern bit 0, oldest with bit len-1
                    m = 1'b1;
                    for (int k = 0; k < m_len; k++)
                        if (q[q.size() - 1 - k] != m_pat[k]) m = 1'b0;
                end
                if (m && !m_ovl) q.delete();
                while (q.size() > MAX_LEN) void'(q.pop_front());
            end
            if (clr) begin
                exp_cnt = 0; exp_sat = 1'b0; exp_cnt2 = 0; exp_sat2 = 1'b0;
            end else if (m) begin
                if (exp_cnt == 255) exp_sat = 1'b1; else exp_cnt++;
                if (exp_cnt2 == 3) exp_sat2 = 1'b1; else exp_cnt2++;
            end
        end
        exp_y = m;
        #1;
        if (y === 1'b1) dut_pulses++;
        x_valid = 1'b0; cfg_load = 1'b0; cnt_clr = 1'b0; rst = 1'b0;
    endtask

    task automatic test_reset();
        cyc(1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        tests++;
        if (y !== 1'b0) begin fails++; $display("FAIL reset_y got=%b want=0", y); end
        tests++;
        if (match_cnt !== 8'd0) begin fails++; $display("FAIL reset_cnt got=%0d want=0", match_cnt); end
        tests++;
        if (cnt_sat !== 1'b0 || cnt_sat2 !== 1'b0) begin
            fails++; $display("FAIL reset_sat got=%b/%b want=0/0", cnt_sat, cnt_sat2);
        end
    endtask

    task automatic test_basic();
        bit bits[4] = '{1'b0, 1'b0, 1'b0, 1'b1};
        for (int i = 0; i < 4; i++) begin
            cyc(bits[i], 1'b1, 1'b0, 1'b0, 1'b0);
            tests++;
            if (y !== exp_y) begin fails++; $display("FAIL basic_y bit%0d got=%b want=%b", i, y, exp_y); end
        end
        tests++;
        if (y !== 1'b1 || match_cnt !== 8'd1) begin
            fails++; $display("FAIL basic_match y=%b cnt=%0d want y=1 cnt=1", y, match_cnt);
        end
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        tests++;
        if (y !== 1'b0) begin fails++; $display("FAIL basic_pulse_width got=%b want=0", y); end
    endtask

    task automatic test_overlap_modes();
        bit bits[5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        for (int mode = 1; mode >= 0; mode--) begin
            cfg_pattern = 8'b1111_0101;   // junk above bit 2 must be ignored
            cfg_len     = 4'd3;
            cfg_overlap = mode[0];
            cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
            dut_pulses = 0;
            for (int i = 0; i < 5; i++) begin
                cyc(bits[i], 1'b1, 1'b0, 1'b0, 1'b0);
                tests++;
                if (y !== exp_y) begin fails++; $display("FAIL ovl%0d_y bit%0d got=%b want=%b", mode, i, y, exp_y); end
            end
            cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
            tests++;
            if (dut_pulses != ((mode == 1) ? 2 : 1)) begin
                fails++; $display("FAIL ovl%0d_pulses got=%0d want=%0d", mode, dut_pulses, (mode == 1) ? 2 : 1);
            end
            tests++;
            if (match_cnt !== 8'(exp_cnt)) begin
                fails++; $display("FAIL ovl%0d_cnt got=%0d want=%0d", mode, match_cnt, exp_cnt);
            end
        end
    endtask

    task automatic test_gaps();
        bit bits[4] = '{1'b0, 1'b0, 1'b0, 1'b1};
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        dut_pulses = 0;
        for (int i = 0; i < 4; i++) begin
            for (int g = 0; g < int'($urandom_range(1, 3)); g++) begin
                cyc(1'($urandom), 1'b0, 1'b0, 1'b0, 1'b0);
                tests++;
                if (y !== exp_y) begin fails++; $display("FAIL gap_y bit%0d got=%b want=%b", i, y, exp_y); end
            end
            cyc(bits[i], 1'b1, 1'b0, 1'b0, 1'b0);
            tests++;
            if (y !== exp_y) begin fails++; $display("FAIL gap_valid_y bit%0d got=%b want=%b", i, y, exp_y); end
        end
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        tests++;
        if (dut_pulses != 1 || match_cnt !== 8'd1) begin
            fails++; $display("FAIL gap_total pulses=%0d cnt=%0d want 1/1", dut_pulses, match_cnt);
        end
    endtask

    task automatic test_cfg_midstream();
        bit seq_a5[8] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        cfg_pattern = 8'h03; cfg_len = 4'd2; cfg_overlap = 1'b1;
        cyc(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);          // x on the load edge is dropped
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        tests++;
        if (y !== 1'b0 || y !== exp_y) begin fails++; $display("FAIL midload_first got=%b want=0", y); end
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        tests++;
        if (y !== 1'b1 || y !== exp_y) begin fails++; $display("FAIL midload_second got=%b want=1", y); end
        // cfg_len 0 clamps to 2: pattern "10"
        cfg_pattern = 8'hF6; cfg_len = 4'd0;
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        tests++;
        if (y !== 1'b0) begin fails++; $display("FAIL len0_first got=%b want=0", y); end
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        tests++;
        if (y !== 1'b1) begin fails++; $display("FAIL len0_match got=%b want=1", y); end
        // cfg_len 15 clamps to 8
        cfg_pattern = 8'hA5; cfg_len = 4'd15;
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) begin
            cyc(seq_a5[i], 1'b1, 1'b0, 1'b0, 1'b0);
            tests++;
            if (y !== exp_y || y !== (i == 7)) begin
                fails++; $display("FAIL len15_y bit%0d got=%b want=%b", i, y, exp_y);
            end
        end
    endtask

    task automatic test_saturation();
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        cfg_pattern = 8'h03; cfg_len = 4'd2; cfg_overlap = 1'b1;
        cyc(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);          // load and clear together
        for (int i = 0; i < 6; i++) cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        tests++;
        if (match_cnt2 !== 2'd3 || cnt_sat2 !== 1'b1) begin
            fails++; $display("FAIL sat_small cnt=%0d sat=%b want 3/1", match_cnt2, cnt_sat2);
        end
        tests++;
        if (match_cnt !== 8'd5 || cnt_sat !== 1'b0) begin
            fails++; $display("FAIL sat_wide cnt=%0d sat=%b want 5/0", match_cnt, cnt_sat);
        end
        // load alone must not disturb the count
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        tests++;
        if (match_cnt !== 8'd5) begin fails++; $display("FAIL load_keeps_cnt got=%0d want=5", match_cnt); end
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        tests++;
        if (match_cnt2 !== 2'd0 || cnt_sat2 !== 1'b0 || match_cnt !== 8'd0) begin
            fails++; $display("FAIL clr cnt2=%0d sat2=%b cnt=%0d want 0/0/0", match_cnt2, cnt_sat2, match_cnt);
        end
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);          // match coincident with clear
        tests++;
        if (y !== 1'b1 || match_cnt !== 8'd0) begin
            fails++; $display("FAIL clr_wins y=%b cnt=%0d want y=1 cnt=0", y, match_cnt);
        end
    endtask

    task automatic test_reset_on_y();
        bit bits[4] = '{1'b0, 1'b0, 1'b0, 1'b1};
        cfg_pattern = 8'h03; cfg_len = 4'd2; cfg_overlap = 1'b0;
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        tests++;
        if (y !== 1'b1) begin fails++; $display("FAIL rsty_setup got=%b want=1", y); end
        cyc(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
        tests++;
        if (y !== 1'b0 || match_cnt !== 8'd0) begin
            fails++; $display("FAIL rsty_clear y=%b cnt=%0d want 0/0", y, match_cnt);
        end
        dut_pulses = 0;
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        tests++;
        if (dut_pulses != 0) begin fails++; $display("FAIL rsty_oldcfg pulses=%0d want=0", dut_pulses); end
        for (int i = 0; i < 4; i++) cyc(bits[i], 1'b1, 1'b0, 1'b0, 1'b0);
        tests++;
        if (y !== 1'b1 || dut_pulses != 1) begin
            fails++; $display("FAIL rsty_restored y=%b pulses=%0d want 1/1", y, dut_pulses);
        end
    endtask

    task automatic test_random();
        int r;
        bit rs, ld, clr;
        for (int n = 0; n < 3000; n++) begin
            r   = int'($urandom_range(0, 199));
            rs  = (r < 2);
            ld  = (r >= 2 && r < 10);
            clr = (int'($urandom_range(0, 99)) < 3);
            if (ld) begin
                cfg_pattern = 8'($urandom);
                cfg_len     = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15))
                                                          : 4'($urandom_range(2, 4));
                cfg_overlap = 1'($urandom);
            end
            cyc(1'($urandom), ($urandom_range(0, 3) != 0), ld, clr, rs);
            tests++;
            if (y !== exp_y || y2 !== exp_y || match_cnt !== 8'(exp_cnt) || cnt_sat !== exp_sat ||
                match_cnt2 !== 2'(exp_cnt2) || cnt_sat2 !== exp_sat2) begin
                fails++;
                if (fails < 20)
                    $display("FAIL rand_%0d y=%b/%b cnt=%0d sat=%b cnt2=%0d sat2=%b want y=%b cnt=%0d sat=%b cnt2=%0d sat2=%b",
                             n, y, y2, match_cnt, cnt_sat, match_cnt2, cnt_sat2,
                             exp_y, exp_cnt, exp_sat, exp_cnt2, exp_sat2);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_overlap_modes();
        test_gaps();
        test_cfg_midstream();
        test_saturation();
        test_reset_on_y();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
